alu_bcd_serial: RTL

- Parametrised successor to the 8-bit combinational 65xx ALU: an N-digit (4*DIGITS-bit) ALU with binary and BCD add/subtract, logic, rotate and pass.
- Arithmetic runs digit-serially, one 4-bit digit per clock, LSB digit first; logic, rotate and pass ops complete in one cycle.
- Operands are latched on start; results and flags are registered with a valid pulse.
- Sits behind the datapath input muxes of wide-register cores (16-bit A/X/Y modes); the sequencer stalls on busy.

---
 rtl/alu_bcd_serial_pkg.sv | 19 +
 rtl/alu_bcd_serial_slice.sv | 19 +
 rtl/alu_bcd_serial.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_bcd_serial_pkg.sv
// alu_bcd_serial_pkg: op codes, FSM state encodings and helpers shared by the serial ALU.
package alu_bcd_serial_pkg;

    localparam logic [3:0] ALU_ORA = 4'h0;
    localparam logic [3:0] ALU_AND = 4'h1;
    localparam logic [3:0] ALU_EOR = 4'h2;
    localparam logic [3:0] ALU_ADC = 4'h3;
    localparam logic [3:0] ALU_SBC = 4'h4;
    localparam logic [3:0] ALU_ROR = 4'h5;
    localparam logic [3:0] ALU_PSA = 4'h6;

    localparam logic [0:0] ALU_ST_IDLE  = 1'b0;
    localparam logic [0:0] ALU_ST_ARITH = 1'b1;

    function automatic logic is_arith(input logic [3:0] o);
        return o == ALU_ADC || o == ALU_SBC;
    endfunction

endpackage

// File: rtl/alu_bcd_serial_slice.sv
// alu_digit_slice: one 4-bit digit of add/subtract with optional decimal adjust.
module alu_digit_slice (
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       cin,
    input  logic       dec,
    input  logic       sub,
    output logic [3:0] digit,
    output logic       cout,
    output logic       raw_msb
);
    logic [4:0] s;
    always_comb begin
        s       = {1'b0, a_d} + {1'b0, b_d} + {4'b0, cin};
        cout    = dec && !sub ? s[4] | (s[3] & (s[2] | s[1])) : s[4];
        digit   = !dec ? s[3:0] : sub ? (cout ? s[3:0] : s[3:0] + 4'd10) : (cout ? s[3:0] + 4'd6 : s[3:0]);
        raw_msb = s[3];
    end
endmodule

// File: rtl/alu_bcd_serial.sv
// alu_bcd_serial: DIGITS-wide ALU; add/subtract run one digit per clock LSB first,
// logic/rotate/pass ops finish in a single cycle.
module alu_bcd_serial
    import alu_bcd_serial_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic              dec,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic              c_in,
    output logic              busy,
    output logic              valid,
    output logic [4*DIGITS-1:0] result,
    output logic              c_out,
    output logic              v_out,
    output logic              n_out,
    output logic              z_out,
    output logic              hc_out
);
    localparam int W = 4 * DIGITS;

    logic [0:0]   state;
    logic [2:0]   k;
    logic [W-1:0] a_sh, b_sh, res_arith, res_logic;
    logic         carry, dec_r, sub_r, c_logic;
    logic [3:0]   digit;
    logic         cn, raw_msb, last;

    alu_digit_slice u_slice (
        .a_d     (a_sh[3:0]),
        .b_d     (b_sh[3:0]),
        .cin     (carry),
        .dec     (dec_r),
        .sub     (sub_r),
        .digit   (digit),
        .cout    (cn),
        .raw_msb (raw_msb)
    );

    // Operands shift right each cycle so the slice always sees digit k at [3:0];
    // result fills from the top and is aligned after the last digit.
    always_comb begin
        last      = k == 3'(DIGITS - 1);
        busy      = state == ALU_ST_ARITH;
        res_arith = (result >> 4) | (W'(digit) << (W - 4));
        res_logic = op == ALU_ORA ? a | b :
                    op == ALU_AND ? a & b :
                    op == ALU_EOR ? a ^ b :
                    op == ALU_ROR ? {c_in, a[W-1:1]} : a;
        c_logic   = op == ALU_ROR && a[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ALU_ST_IDLE;
            k      <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            dec_r  <= 1'b0;
            sub_r  <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
            c_out  <= 1'b0;
            v_out  <= 1'b0;
            n_out  <= 1'b0;
            z_out  <= 1'b1;
            hc_out <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == ALU_ST_IDLE) begin
                if (start && is_arith(op)) begin
                    state <= ALU_ST_ARITH;
                    a_sh  <= a;
                    b_sh  <= op == ALU_SBC ? ~b : b;
                    carry <= c_in;
                    dec_r <= dec;
                    sub_r <= op == ALU_SBC;
                    k     <= '0;
                end else if (start) begin
                    result <= res_logic;
                    c_out  <= c_logic;
                    v_out  <= 1'b0;
                    n_out  <= res_logic[W-1];
                    z_out  <= res_logic == '0;
                    hc_out <= 1'b0;
                    valid  <= 1'b1;
                end
            end else begin
                a_sh   <= a_sh >> 4;
                b_sh   <= b_sh >> 4;
                carry  <= cn;
                k      <= k + 3'd1;
                result <= res_arith;
                if (k == '0) hc_out <= cn;
                if (last) begin
                    state <= ALU_ST_IDLE;
                    valid <= 1'b1;
                    c_out <= cn;
                    v_out <= a_sh[3] == b_sh[3] && a_sh[3] != raw_msb;
                    n_out <= res_arith[W-1];
                    z_out <= res_arith == '0;
                end
            end
        end
    end
endmodule
